vga_sync_gen: RTL and testbench

- Generates VGA raster timing for the 640x480 text display.
- Sits directly upstream of the font/tile pixel generator and feeds it pixel_x, pixel_y and video_on.
- Also outputs hsync, vsync and video_on delayed by a fixed pipeline depth, so the sync pins line up with the downstream RGB. The pixel generator's RGB lags its pixel coordinates by 2 clk (tile RAM read, then font ROM read).

---
 rtl/vga_sync_gen.sv | 120 ++++++++++++
 tb/tb_vga_sync_gen.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// VGA raster timing: prescaled h/v counters, sync/blank decode, and a PIPE_DELAY-clk delay line on the syncs.
// Coordinates and decodes are valid the clk the counters update; *_d outputs lag by PIPE_DELAY clk; no backpressure.
module vga_sync_gen #(
  parameter int H_DISPLAY  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_DISPLAY  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int SYNC_POL   = 0,
  parameter int CLK_DIV    = 2,
  parameter int PIPE_DELAY = 2
) (
  input  logic       clk,
  input  logic       reset,
  output logic       pixel_tick,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_start,
  output logic       hsync_d,
  output logic       vsync_d,
  output logic       video_on_d
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS  = 10'(V_DISPLAY);
  localparam logic [9:0] HS_BEG = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_END = 10'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_END = 10'(V_DISPLAY + V_FRONT + V_SYNC);
  localparam logic [1:0] DIV_LAST = 2'(CLK_DIV - 1);
  localparam logic       ACT = (SYNC_POL != 0);

  if (CLK_DIV < 1 || CLK_DIV > 4) begin : g_bad_div
    $error("vga_sync_gen: CLK_DIV must be in 1..4");
  end
  if (PIPE_DELAY < 0 || PIPE_DELAY > 7) begin : g_bad_dly
    $error("vga_sync_gen: PIPE_DELAY must be in 0..7");
  end

  logic [1:0] div;
  logic [9:0] h;
  logic [9:0] v;

  assign pixel_tick = (div == DIV_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      div         <= '0;
      h           <= '0;
      v           <= '0;
      frame_start <= 1'b0;
    end else begin
      div         <= pixel_tick ? 2'd0 : div + 2'd1;
      frame_start <= 1'b0;
      if (pixel_tick) begin
        if (h == H_LAST) begin
          h <= '0;
          if (v == V_LAST) begin
            v           <= '0;
            frame_start <= 1'b1;
          end else begin
            v <= v + 10'd1;
          end
        end else begin
          h <= h + 10'd1;
        end
      end
    end
  end

  assign pixel_x  = h;
  assign pixel_y  = v;
  assign video_on = (h < H_VIS) && (v < V_VIS);
  assign hsync    = ((h >= HS_BEG) && (h < HS_END)) ? ACT : ~ACT;
  assign vsync    = ((v >= VS_BEG) && (v < VS_END)) ? ACT : ~ACT;

  // Free-running shift regs so the syncs line up with RGB coming out of the tile/font read pipeline.
  if (PIPE_DELAY == 0) begin : g_nodly
    assign hsync_d    = hsync;
    assign vsync_d    = vsync;
    assign video_on_d = video_on;
  end else begin : g_dly
    logic [PIPE_DELAY-1:0] hs_q;
    logic [PIPE_DELAY-1:0] vs_q;
    logic [PIPE_DELAY-1:0] von_q;

    always_ff @(posedge clk) begin
      if (reset) begin
        hs_q  <= {PIPE_DELAY{~ACT}};
        vs_q  <= {PIPE_DELAY{~ACT}};
        von_q <= '0;
      end else begin
        hs_q[0]  <= hsync;
        vs_q[0]  <= vsync;
        von_q[0] <= video_on;
        for (int i = 1; i < PIPE_DELAY; i++) begin
          hs_q[i]  <= hs_q[i-1];
          vs_q[i]  <= vs_q[i-1];
          von_q[i] <= von_q[i-1];
        end
      end
    end

    assign hsync_d    = hs_q[PIPE_DELAY-1];
    assign vsync_d    = vs_q[PIPE_DELAY-1];
    assign video_on_d = von_q[PIPE_DELAY-1];
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboarded bench for vga_sync_gen: default 640x480 timing plus two reduced geometries with other CLK_DIV/PIPE_DELAY/SYNC_POL.
module tb_vga_sync_gen;

  typedef struct { int hd, hf, hs, hb, vd, vf, vs, vb, pol, div, pd; } cfg_t;
  typedef struct { int tick, x, y, von, hs, vs, fs, hsd, vsd, vond; } obs_t;
  typedef struct { longint g; obs_t e; } rec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int     tests = 0;
  int     fails = 0;
  cfg_t   cfg [3];
  obs_t   obs [3];
  rec_t   sbq [3][$];
  int     mism [3] = '{0, 0, 0};
  longint gclk = 0;
  longint cyc = 0;
  int     epoch = 0;
  bit     armed = 0;
  logic   prev_rst = 1'b0;

  int hs5_low = 0, vs5_low = 0, von0_low = 0, d1_vs_act = 0, d1_tick_low = 0, d1_fs = 0, d2_ticks = 0;
  longint last_fs = -1;

  // Directed default-timing vectors: cyc, tick, x, y, von, hs, vs, fs, hsd, vsd, vond
  int lit [12][11] = '{
    '{   1, 1,   0, 0, 1, 1, 1, 0, 1, 1, 0},
    '{   2, 0,   1, 0, 1, 1, 1, 0, 1, 1, 1},
    '{   3, 1,   1, 0, 1, 1, 1, 0, 1, 1, 1},
    '{1280, 0, 640, 0, 0, 1, 1, 0, 1, 1, 1},
    '{1282, 0, 641, 0, 0, 1, 1, 0, 1, 1, 0},
    '{1599, 1, 799, 0, 0, 1, 1, 0, 1, 1, 0},
    '{1600, 0,   0, 1, 1, 1, 1, 0, 1, 1, 0},
    '{1602, 0,   1, 1, 1, 1, 1, 0, 1, 1, 1},
    '{9312, 0, 656, 5, 0, 0, 1, 0, 1, 1, 0},
    '{9314, 0, 657, 5, 0, 0, 1, 0, 0, 1, 0},
    '{9504, 0, 752, 5, 0, 1, 1, 0, 0, 1, 0},
    '{9506, 0, 753, 5, 0, 1, 1, 0, 1, 1, 0}
  };
  int l1 [18] = '{1, 2, 3, 7, 8, 9, 14, 15, 16, 74, 75, 104, 105, 119, 120, 121, 122, 240};
  int l2 [20] = '{1, 2, 3, 4, 5, 6, 35, 36, 37, 38, 39, 44, 45, 46, 47, 485, 486, 487, 488, 489};

  logic       t0, t1, t2;
  logic [9:0] x0, x1, x2, y0, y1, y2;
  logic       von0, von1, von2, hs0, hs1, hs2, vs0, vs1, vs2, fs0, fs1, fs2;
  logic       hsd0, hsd1, hsd2, vsd0, vsd1, vsd2, vond0, vond1, vond2;

  vga_sync_gen u0 (
    .clk(clk), .reset(reset), .pixel_tick(t0), .pixel_x(x0), .pixel_y(y0), .video_on(von0),
    .hsync(hs0), .vsync(vs0), .frame_start(fs0), .hsync_d(hsd0), .vsync_d(vsd0), .video_on_d(vond0)
  );

  vga_sync_gen #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2), .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .SYNC_POL(1), .CLK_DIV(1), .PIPE_DELAY(0)
  ) u1 (
    .clk(clk), .reset(reset), .pixel_tick(t1), .pixel_x(x1), .pixel_y(y1), .video_on(von1),
    .hsync(hs1), .vsync(vs1), .frame_start(fs1), .hsync_d(hsd1), .vsync_d(vsd1), .video_on_d(vond1)
  );

  vga_sync_gen #(
    .H_DISPLAY(10), .H_FRONT(2), .H_SYNC(3), .H_BACK(3), .V_DISPLAY(5), .V_FRONT(1), .V_SYNC(1), .V_BACK(2),
    .SYNC_POL(0), .CLK_DIV(3), .PIPE_DELAY(3)
  ) u2 (
    .clk(clk), .reset(reset), .pixel_tick(t2), .pixel_x(x2), .pixel_y(y2), .video_on(von2),
    .hsync(hs2), .vsync(vs2), .frame_start(fs2), .hsync_d(hsd2), .vsync_d(vsd2), .video_on_d(vond2)
  );

  always_comb begin
    obs[0] = '{int'(t0), int'(x0), int'(y0), int'(von0), int'(hs0), int'(vs0), int'(fs0), int'(hsd0), int'(vsd0), int'(vond0)};
    obs[1] = '{int'(t1), int'(x1), int'(y1), int'(von1), int'(hs1), int'(vs1), int'(fs1), int'(hsd1), int'(vsd1), int'(vond1)};
    obs[2] = '{int'(t2), int'(x2), int'(y2), int'(von2), int'(hs2), int'(vs2), int'(fs2), int'(hsd2), int'(vsd2), int'(vond2)};
  end

  // Expected undelayed outputs t clk after the last reset edge, from elapsed time alone.
  function automatic obs_t src_at(cfg_t c, longint t);
    obs_t   e;
    longint pix, ht, vt;
    int     p;
    ht  = c.hd + c.hf + c.hs + c.hb;
    vt  = c.vd + c.vf + c.vs + c.vb;
    p   = (c.pol != 0) ? 1 : 0;
    pix = t / c.div;
    e.x    = int'(pix % ht);
    e.y    = int'((pix / ht) % vt);
    e.tick = ((t % c.div) == c.div - 1) ? 1 : 0;
    e.von  = (e.x < c.hd && e.y < c.vd) ? 1 : 0;
    e.hs   = (e.x >= c.hd + c.hf && e.x < c.hd + c.hf + c.hs) ? p : 1 - p;
    e.vs   = (e.y >= c.vd + c.vf && e.y < c.vd + c.vf + c.vs) ? p : 1 - p;
    e.fs   = (t > 0 && (t % (c.div * ht * vt)) == 0) ? 1 : 0;
    e.hsd  = 1 - p;
    e.vsd  = 1 - p;
    e.vond = 0;
    return e;
  endfunction

  function automatic obs_t exp_at(cfg_t c, longint t);
    obs_t e, d;
    e = src_at(c, t);
    if (t >= c.pd) begin
      d      = src_at(c, t - c.pd);
      e.hsd  = d.hs;
      e.vsd  = d.vs;
      e.vond = d.von;
    end
    return e;
  endfunction

  function automatic bit same(obs_t a, obs_t b);
    return a.tick == b.tick && a.x == b.x && a.y == b.y && a.von == b.von && a.hs == b.hs &&
           a.vs == b.vs && a.fs == b.fs && a.hsd == b.hsd && a.vsd == b.vsd && a.vond == b.vond;
  endfunction

  task automatic cmp(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_obs(string tag, obs_t a, obs_t e);
    cmp({tag, " pixel_tick"}, a.tick, e.tick);
    cmp({tag, " pixel_x"}, a.x, e.x);
    cmp({tag, " pixel_y"}, a.y, e.y);
    cmp({tag, " video_on"}, a.von, e.von);
    cmp({tag, " hsync"}, a.hs, e.hs);
    cmp({tag, " vsync"}, a.vs, e.vs);
    cmp({tag, " frame_start"}, a.fs, e.fs);
    cmp({tag, " hsync_d"}, a.hsd, e.hsd);
    cmp({tag, " vsync_d"}, a.vsd, e.vsd);
    cmp({tag, " video_on_d"}, a.vond, e.vond);
  endtask

  task automatic push(int d, longint g, obs_t e);
    rec_t r;
    r.g = g;
    r.e = e;
    sbq[d].push_back(r);
  endtask

  always @(posedge clk) begin
    gclk++;
    if (reset) begin
      cyc = 0;
      if (!prev_rst) epoch++;
    end else begin
      cyc++;
    end
    prev_rst = reset;
    armed    = 1;
  end

  obs_t mon_e;
  rec_t mon_r;

  always @(negedge clk) begin
    if (armed) begin
      for (int d = 0; d < 3; d++) begin
        mon_e = exp_at(cfg[d], cyc);
        if (!same(obs[d], mon_e)) mism[d]++;
        while (sbq[d].size() > 0 && sbq[d][0].g < gclk) begin
          mon_r = sbq[d].pop_front();
          tests++;
          fails++;
          $display("FAIL sb_missed dut%0d: record due at clk %0d not seen, now clk %0d", d, mon_r.g, gclk);
        end
        if (sbq[d].size() > 0 && sbq[d][0].g == gclk) begin
          mon_r = sbq[d].pop_front();
          check_obs($sformatf("dut%0d cyc%0d", d, cyc), obs[d], mon_r.e);
        end
      end
      if (epoch == 1) begin
        if (cyc >= 8000 && cyc < 9600) begin
          hs5_low += (obs[0].hs == 0) ? 1 : 0;
          vs5_low += (obs[0].vs == 0) ? 1 : 0;
        end
        if (cyc >= 1 && cyc < 1600) von0_low += (obs[0].von == 0) ? 1 : 0;
        if (cyc >= 1 && cyc < 120) d1_vs_act += (obs[1].vs == 1) ? 1 : 0;
        if (cyc >= 1) d1_tick_low += (obs[1].tick == 0) ? 1 : 0;
        if (cyc >= 1 && cyc <= 9600) d1_fs += obs[1].fs;
        if (cyc >= 1 && cyc < 486) d2_ticks += obs[2].tick;
      end
      if (reset) begin
        last_fs = -1;
      end else if (obs[1].fs == 1) begin
        if (last_fs >= 0) cmp("d1_frame_period_clk", int'(gclk - last_fs), 120);
        last_fs = gclk;
      end
    end
  end

  task automatic run_reset(int n, output longint base);
    longint g0;
    g0 = gclk + 1;
    for (int k = 0; k < n; k++)
      for (int d = 0; d < 3; d++) push(d, g0 + k, exp_at(cfg[d], 0));
    reset = 1'b1;
    repeat (n) @(posedge clk);
    #1 reset = 1'b0;
    base = g0 + n - 1;
  endtask

  task automatic push_vectors(longint base, int limit);
    obs_t e;
    for (int i = 0; i < 12; i++) begin
      if (lit[i][0] <= limit) begin
        e = '{lit[i][1], lit[i][2], lit[i][3], lit[i][4], lit[i][5], lit[i][6], lit[i][7], lit[i][8], lit[i][9], lit[i][10]};
        push(0, base + lit[i][0], e);
      end
    end
    for (int i = 0; i < 18; i++)
      if (l1[i] <= limit) push(1, base + l1[i], exp_at(cfg[1], l1[i]));
    for (int i = 0; i < 20; i++)
      if (l2[i] <= limit) push(2, base + l2[i], exp_at(cfg[2], l2[i]));
  endtask

  initial begin
    longint base;
    cfg[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 0, 2, 2};
    cfg[1] = '{8, 2, 3, 2, 4, 1, 2, 1, 1, 1, 0};
    cfg[2] = '{10, 2, 3, 3, 5, 1, 1, 2, 0, 3, 3};

    run_reset(3, base);
    push_vectors(base, 9600);
    repeat (9700) @(posedge clk);
    #1;

    // Reset again mid-frame (default timing sits at line 6, x=50)
    run_reset(3, base);
    push_vectors(base, 3000);
    repeat (3300) @(posedge clk);
    #1;
    @(negedge clk);
    #1;

    cmp("d0_hsync_low_clk_line5", hs5_low, 192);
    cmp("d0_vsync_low_clk_line5", vs5_low, 0);
    cmp("d0_video_off_clk_line0", von0_low, 320);
    cmp("d1_vsync_active_clk_frame0", d1_vs_act, 30);
    cmp("d1_tick_low_clk", d1_tick_low, 0);
    cmp("d1_frame_start_pulses", d1_fs, 80);
    cmp("d2_ticks_frame0", d2_ticks, 162);
    for (int d = 0; d < 3; d++) begin
      cmp($sformatf("dut%0d_cycle_mismatches", d), mism[d], 0);
      cmp($sformatf("dut%0d_sb_leftover", d), sbq[d].size(), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
